// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: aligns to SYNC, stages slots 0..2 and
// publishes complete frames on Q0..Q3 together with a FRAME_DONE pulse.
module tdm_demux4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             VALID,
    input  logic             SYNC,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [1:0]       CH,
    output logic             LOCKED,
    output logic             FRAME_DONE,
    output logic             SYNC_ERR
);

    typedef enum logic [0:0] {StHunt, StLock} state_e;

    state_e           state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [WIDTH-1:0] s0_q, s1_q, s2_q, s0_d, s1_d, s2_d;
    logic [WIDTH-1:0] q0_q, q1_q, q2_q, q3_q, q0_d, q1_d, q2_d, q3_d;
    logic             frame_done_q, frame_done_d;
    logic             sync_err_q, sync_err_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StHunt;
            ch_q         <= '0;
            s0_q         <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            q0_q         <= '0;
            q1_q         <= '0;
            q2_q         <= '0;
            q3_q         <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            q0_q         <= q0_d;
            q1_q         <= q1_d;
            q2_q         <= q2_d;
            q3_q         <= q3_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        s0_d         = s0_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        q0_d         = q0_q;
        q1_d         = q1_q;
        q2_d         = q2_q;
        q3_d         = q3_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        if (VALID) begin
            unique case (state_q)
                StHunt: begin
                    if (SYNC) begin
                        s0_d    = DIN;
                        ch_d    = 2'd1;
                        state_d = StLock;
                    end
                end
                StLock: begin
                    if (SYNC) begin
                        // Early sync abandons the partial frame and restarts at slot 0.
                        sync_err_d = (ch_q != 2'd0);
                        s0_d       = DIN;
                        ch_d       = 2'd1;
                    end else begin
                        unique case (ch_q)
                            2'd0: begin
                                sync_err_d = 1'b1;
                                state_d    = StHunt;
                                ch_d       = 2'd0;
                            end
                            2'd1: begin
                                s1_d = DIN;
                                ch_d = 2'd2;
                            end
                            2'd2: begin
                                s2_d = DIN;
                                ch_d = 2'd3;
                            end
                            2'd3: begin
                                q0_d         = s0_q;
                                q1_d         = s1_q;
                                q2_d         = s2_q;
                                q3_d         = DIN;
                                frame_done_d = 1'b1;
                                ch_d         = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    assign Q0         = q0_q;
    assign Q1         = q1_q;
    assign Q2         = q2_q;
    assign Q3         = q3_q;
    assign CH         = ch_q;
    assign LOCKED     = (state_q == StLock);
    assign FRAME_DONE = frame_done_q;
    assign SYNC_ERR   = sync_err_q;

endmodule
